// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole sequencer; picks holes from an LFSR, times each mole on the
// frame tick, judges hammer strikes against the hole rectangles and tracks score, misses, win and lose.
module mole_scheduler #(
    parameter int         UP_TICKS  = 60,
    parameter int         GAP_TICKS = 30,
    parameter int         WIN_SCORE = 10,
    parameter int         MAX_MISS  = 3,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        center,
    input  logic [10:0] blkpos_x,
    input  logic [10:0] blkpos_y,
    output logic        top_left,
    output logic        top_center,
    output logic        top_right,
    output logic        bottom_left,
    output logic        bottom_center,
    output logic        bottom_right,
    output logic        win,
    output logic        lose,
    output logic [7:0]  score,
    output logic [3:0]  misses
);
    typedef enum logic [2:0] {IDLE, GAP, UP, WON, LOST} state_t;
    localparam logic [7:0]  SEED  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [15:0] GAP_T = 16'(GAP_TICKS);
    localparam logic [15:0] UP_T  = 16'(UP_TICKS);
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [2:0]  prev_hole_q, prev_hole_d;
    logic [5:0]  mole_q, mole_d;
    logic        win_q, win_d, lose_q, lose_d, center_q;
    logic [7:0]  score_q, score_d, score_inc;
    logic [3:0]  misses_q, misses_d, misses_inc;
    logic [11:0] sx, sy, x0, y0;
    logic [2:0]  h_mod, h_new;
    logic        strike, in_hole, last_tick;
    assign strike     = center & ~center_q;
    assign sx         = {1'b0, blkpos_x} + 12'd50;
    assign sy         = {1'b0, blkpos_y};
    // prev_hole_q is the hole currently up while in UP
    assign x0         = (prev_hole_q == 3'd0 || prev_hole_q == 3'd3) ? 12'd288 :
                        (prev_hole_q == 3'd1 || prev_hole_q == 3'd4) ? 12'd609 : 12'd929;
    assign y0         = (prev_hole_q < 3'd3) ? 12'd169 : 12'd569;
    assign in_hole    = sx >= x0 && sx <= x0 + 12'd99 && sy >= y0 && sy <= y0 + 12'd79;
    assign last_tick  = timer_q == 16'd1;
    assign h_mod      = (lfsr_q[2:0] >= 3'd6) ? lfsr_q[2:0] - 3'd6 : lfsr_q[2:0];
    assign h_new      = (h_mod != prev_hole_q) ? h_mod : (h_mod == 3'd5) ? 3'd0 : h_mod + 3'd1;
    assign score_inc  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    assign misses_inc = (misses_q == 4'hF) ? misses_q : misses_q + 4'd1;
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        prev_hole_d = prev_hole_q;
        mole_d      = mole_q;
        win_d       = win_q;
        lose_d      = lose_q;
        score_d     = score_q;
        misses_d    = misses_q;
        lfsr_d      = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        case (state_q)
            IDLE, WON, LOST: begin
                mole_d = '0;
                if (start) begin
                    state_d  = GAP;
                    timer_d  = GAP_T;
                    score_d  = '0;
                    misses_d = '0;
                    win_d    = 1'b0;
                    lose_d   = 1'b0;
                end
            end
            GAP: begin
                mole_d = '0;
                if (tick && last_tick) begin
                    state_d     = UP;
                    timer_d     = UP_T;
                    prev_hole_d = h_new;
                    mole_d      = 6'd1 << h_new;
                end else if (tick) begin
                    timer_d = timer_q - 16'd1;
                end
            end
            UP: begin
                // a hit wins over a timeout landing on the same cycle
                if (strike && in_hole) begin
                    mole_d  = '0;
                    score_d = score_inc;
                    timer_d = GAP_T;
                    win_d   = score_inc == 8'(WIN_SCORE);
                    state_d = (score_inc == 8'(WIN_SCORE)) ? WON : GAP;
                end else if (tick && last_tick) begin
                    mole_d   = '0;
                    misses_d = misses_inc;
                    timer_d  = GAP_T;
                    lose_d   = misses_inc == 4'(MAX_MISS);
                    state_d  = (misses_inc == 4'(MAX_MISS)) ? LOST : GAP;
                end else if (tick) begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            lfsr_q      <= SEED;
            prev_hole_q <= 3'd7;
            mole_q      <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            score_q     <= '0;
            misses_q    <= '0;
            center_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lfsr_q      <= lfsr_d;
            prev_hole_q <= prev_hole_d;
            mole_q      <= mole_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            center_q    <= center;
        end
    end
    assign {bottom_right, bottom_center, bottom_left, top_right, top_center, top_left} = mole_q;
    assign win    = win_q;
    assign lose   = lose_q;
    assign score  = score_q;
    assign misses = misses_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed game scenarios checked against a queue of expected output states.
module tb_mole_scheduler;
    localparam int GAP = 30, UPT = 60, WINS = 10, MAXM = 3;
    logic        clk = 0, rst = 1, tick = 0, start = 0, center = 0;
    logic [10:0] blkpos_x = 0, blkpos_y = 0;
    logic        top_left, top_center, top_right, bottom_left, bottom_center, bottom_right;
    logic        win, lose;
    logic [7:0]  score;
    logic [3:0]  misses;
    logic [5:0]  moles;
    logic [7:0]  lfsr_m;
    logic [2:0]  prev_m = 3'd7, cur_h = 3'd0;
    logic [7:0]  exp_score = 0;
    logic [3:0]  exp_miss = 0;
    logic        exp_win = 0, exp_lose = 0;
    int          checks = 0, errors = 0;
    typedef struct { string tag; logic [19:0] v; } exp_t;
    exp_t sb[$];

    mole_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .center(center),
        .blkpos_x(blkpos_x), .blkpos_y(blkpos_y),
        .top_left(top_left), .top_center(top_center), .top_right(top_right),
        .bottom_left(bottom_left), .bottom_center(bottom_center), .bottom_right(bottom_right),
        .win(win), .lose(lose), .score(score), .misses(misses)
    );

    always #5 clk = ~clk;
    assign moles = {bottom_right, bottom_center, bottom_left, top_right, top_center, top_left};
    always @(posedge clk or posedge rst)
        lfsr_m <= rst ? 8'hA5 : ({1'b0, lfsr_m[7:1]} ^ (lfsr_m[0] ? 8'hB8 : 8'h00));

    function automatic logic [2:0] pick(input logic [7:0] l, input logic [2:0] p);
        logic [2:0] h;
        h = l[2:0];
        if (h >= 3'd6) h = h - 3'd6;
        if (h == p) h = (h == 3'd5) ? 3'd0 : h + 3'd1;
        return h;
    endfunction
    function automatic int x0f(input logic [2:0] h);
        return (h % 3 == 0) ? 288 : (h % 3 == 1) ? 609 : 929;
    endfunction
    function automatic int y0f(input logic [2:0] h);
        return (h < 3) ? 169 : 569;
    endfunction

    task automatic cyc(); @(negedge clk); endtask
    task automatic ticks(input int n);
        repeat (n) begin tick = 1; cyc(); tick = 0; cyc(); end
    endtask
    task automatic aim(input int x, input int y);
        blkpos_x = 11'(x); blkpos_y = 11'(y);
    endtask
    task automatic push(input string tag, input logic [5:0] m);
        exp_t e;
        e.tag = tag;
        e.v = {m, exp_win, exp_lose, exp_score, exp_miss};
        sb.push_back(e);
    endtask
    task automatic check();
        exp_t e;
        logic [19:0] obs;
        e = sb.pop_front();
        obs = {moles, win, lose, score, misses};
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: got moles=%b win=%b lose=%b score=%0d misses=%0d, want moles=%b win=%b lose=%b score=%0d misses=%0d",
                   e.tag, obs[19:14], obs[13], obs[12], obs[11:4], obs[3:0],
                   e.v[19:14], e.v[13], e.v[12], e.v[11:4], e.v[3:0]);
        end
    endtask
    task automatic gap_to_up(input string tag);
        logic [2:0] h;
        ticks(GAP - 1);
        push({tag, "_gap"}, 6'd0); check();
        h = pick(lfsr_m, prev_m);
        tick = 1;
        push({tag, "_rise"}, 6'd1 << h);
        cyc();
        tick = 0;
        check();
        prev_m = h; cur_h = h;
    endtask
    task automatic timeout(input string tag);
        ticks(UPT - 1);
        push({tag, "_still_up"}, 6'd1 << cur_h); check();
        exp_miss = exp_miss + 4'd1;
        exp_lose = (exp_miss == MAXM);
        tick = 1;
        push({tag, "_timeout"}, 6'd0);
        cyc();
        tick = 0;
        check();
        cyc();
    endtask
    task automatic hit_at(input string tag, input int x, input int y);
        aim(x, y);
        exp_score = exp_score + 8'd1;
        exp_win = (exp_score == WINS);
        center = 1;
        push(tag, 6'd0);
        cyc();
        check();
        center = 0;
        cyc();
    endtask
    task automatic nohit(input string tag, input int x, input int y);
        aim(x, y);
        center = 1;
        push(tag, 6'd1 << cur_h);
        cyc();
        check();
        center = 0;
        cyc();
    endtask
    task automatic clear_exp();
        exp_score = 0; exp_miss = 0; exp_win = 0; exp_lose = 0;
    endtask
    task automatic do_start(input string tag);
        start = 1;
        clear_exp();
        push(tag, 6'd0);
        cyc();
        start = 0;
        check();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [5:0] any;
        logic [2:0] o;
        repeat (3) cyc();
        push("reset", 6'd0); check();
        rst = 0;
        ticks(200);
        push("idle_200", 6'd0); check();
        checks++;
        assert (dut.lfsr_q === lfsr_m && lfsr_m != 8'h00) else begin
            errors++; $error("FAIL lfsr_value: got %h want %h (nonzero)", dut.lfsr_q, lfsr_m);
        end
        a = lfsr_m;
        cyc();
        checks++;
        assert (dut.lfsr_q !== a) else begin
            errors++; $error("FAIL lfsr_moves: got %h want a value other than %h", dut.lfsr_q, a);
        end
        do_start("start_a");
        gap_to_up("g1"); timeout("g1");
        gap_to_up("g2");
        o = (cur_h == 3'd5) ? 3'd0 : cur_h + 3'd1;
        nohit("g2_other_hole", x0f(o) + 12, y0f(o) + 31);
        nohit("g2_right_edge", x0f(cur_h) + 50, y0f(cur_h) + 31);
        timeout("g2");
        gap_to_up("g3");
        hit_at("g3_corner_hit", x0f(cur_h) + 49, y0f(cur_h) + 79);
        center = 1;
        gap_to_up("g4");
        aim(x0f(cur_h) + 12, y0f(cur_h) + 31);
        cyc(); cyc();
        push("g4_held_no_hit", 6'd1 << cur_h); check();
        center = 0;
        cyc();
        hit_at("g4_repress_hit", x0f(cur_h) + 12, y0f(cur_h) + 31);
        gap_to_up("g5");
        ticks(UPT - 1);
        aim(x0f(cur_h) + 12, y0f(cur_h) + 31);
        tick = 1; center = 1;
        exp_score = exp_score + 8'd1;
        push("g5_hit_and_timeout", 6'd0);
        cyc();
        tick = 0; center = 0;
        check();
        cyc();
        gap_to_up("g6"); timeout("g6");
        ticks(5);
        push("lose_hold", 6'd0); check();
        do_start("restart_from_lose");
        for (int i = 0; i < WINS; i++) begin
            gap_to_up("w");
            hit_at("w_hit", x0f(cur_h) + 12, y0f(cur_h) + 31);
        end
        any = '0;
        repeat (500) begin tick = 1; cyc(); tick = 0; any |= moles; cyc(); end
        checks++;
        assert (any === 6'd0) else begin
            errors++; $error("FAIL win_moles_low: got %b want 000000", any);
        end
        push("win_hold", 6'd0); check();
        do_start("restart_from_win");
        gap_to_up("r");
        ticks(10);
        rst = 1;
        #1;
        clear_exp();
        prev_m = 3'd7;
        push("async_reset_mid_up", 6'd0); check();
        cyc();
        rst = 0;
        cyc();
        do_start("start_after_reset");
        gap_to_up("post_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
